mem_sweep_ctrl: RTL and testbench
=================================

# mem_sweep_ctrl

Sequencer for the single-port-pair block RAM wrapper (`memory`, read-first, registered `dout`, unconditional write every cycle). On command it fills the RAM with a seeded address pattern, reads it back and compares, or both. It reports error count and first failing address, so a reinitialised bitstream's RAM contents can be checked in-fabric. Because the RAM has no write enable, the controller owns `raddr`/`waddr`/`din` at all times and never leaves a stray write on live data.

## Interface
- `WID_MEM`, 2, RAM word width
- `DEPTH_MEM`, 32768, RAM depth; word `DEPTH_MEM-1` is the park/scratch word, never swept or checked
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  command strobe, sampled only in IDLE
- `mode`  in  2  01 FILL, 10 VERIFY, 11 FILL then VERIFY; 00 ignored (start has no effect)
- `seed`  in  WID_MEM  pattern seed, captured on accepted start
- `raddr`  out  32  to RAM read address
- `waddr`  out  32  to RAM write address
- `din`  out  WID_MEM  to RAM write data
- `dout`  in  WID_MEM  from RAM, registered read data (1-cycle latency)
- `busy`  out  1  high in FILL/VERIFY/DRAIN
- `done`  out  1  one-cycle pulse on completion
- `err_count`  out  16  mismatches in last verify, saturates at 16'hFFFF
- `first_err_valid`  out  1  at least one mismatch since last accepted start
- `first_err_addr`  out  32  address of first mismatch, valid with `first_err_valid`

## Operation
- Swept range W = DEPTH_MEM-1 words, addresses 0..W-1. PARK = DEPTH_MEM-1.
- Pattern: pat(a) = a[WID_MEM-1:0] XOR seed_q.
- States: IDLE, FILL, VERIFY, DRAIN, DONE.
- IDLE / DONE: raddr = waddr = PARK, din = 0. Writes land only on the scratch word.
- IDLE: start && mode!=00 → capture seed, clear err_count/first_err_*, addr counter = 0. Go to FILL if mode[0], else VERIFY. Otherwise stay.
- FILL: raddr = waddr = a, din = pat(a), a++. At a = W-1 → VERIFY (a = 0) if mode[1], else DONE.
- VERIFY: raddr = a, a++. Pipeline register holds the previous address p with valid flag v. When v: waddr = p, din = dout (write-back of the value just read, contents preserved), compare dout vs pat(p). When !v (first verify cycle): waddr = PARK, din = 0. At a = W-1 → DRAIN.
- DRAIN: raddr = PARK, last write-back/compare for p = W-1 → DONE.
- Mismatch: err_count += 1 unless already saturated. If !first_err_valid: latch first_err_addr = p, set first_err_valid.
- DONE: done = 1 for one cycle → IDLE.
- start while not IDLE: ignored, not queued.
- Reset mid-operation: returns to IDLE with all outputs at reset values. Swept RAM contents are undefined; PARK receives 0 from the next cycle.
- Results hold after DONE until the next accepted start.

## Timing
- Reset values: busy 0, done 0, err_count 0, first_err_valid 0, first_err_addr 0, raddr = waddr = PARK, din 0.
- All outputs registered or decoded from registered state; no combinational path from `dout` to any address.
- Start accepted at cycle 0; first sweep address appears at cycle 1.
- FILL: cycles 1..W. VERIFY: reads at cycles 1..W of the phase, compares at 2..W+1 (the last in DRAIN).
- done cycle:
  - FILL only: W+1
  - VERIFY only: W+2
  - FILL+VERIFY: 2W+2
- busy falls in the done cycle.
- Read-during-write on the same address returns the old data. The write-back scheme relies on this and never reads and writes the same swept address in one cycle.

## Structure
- Package `mem_sweep_pkg`: state enum, mode encodings (MODE_FILL, MODE_VERIFY, MODE_BOTH), function `pat(addr, seed)`.
- One sub-module, `mem_sweep_cmp`: compare pipeline register (p, v), mismatch detect, saturating counter, first-error latch. The FSM and address counter stay in the top.
- Bench instantiates `mem_sweep_ctrl` together with the existing RAM wrapper.

## Test plan
Bench configuration: DEPTH_MEM = 16, WID_MEM = 2, so W = 15.
- **Fill+verify clean:** mode 11, seed 2'b01, start at cycle 0 → done at cycle 32, err_count 0, first_err_valid 0. RAM[5] = 2'b00 and RAM[6] = 2'b11.
- **Injected fault:** fill with seed 0. Force RAM[9] = 2'b10 (pattern value is 2'b01). Verify with seed 0 → err_count 1, first_err_addr 9, RAM[9] still 2'b10 after verify.
- **Seed mismatch:** fill with seed 0, verify with seed 2'b11 → err_count 15, first_err_addr 0. RAM contents unchanged.
- **Ignored commands:** start pulses during busy, and mode 00 in IDLE → no state change, busy profile identical to a single run.
- **Reset mid-verify:** assert reset at verify cycle 7 → next cycle busy 0, err_count 0, raddr = waddr = 15. A fresh mode 11 run passes.
- **Saturation:** with WID_MEM = 2, DEPTH_MEM = 70000 and a mismatching seed, err_count ends at 16'hFFFF.

Source files
------------

// File: rtl/mem_sweep_pkg.sv
// rtl/mem_sweep_pkg.sv - shared types, mode encodings and sweep pattern for mem_sweep_ctrl
package mem_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_VERIFY,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_FILL   = 2'b01;
    localparam logic [1:0] MODE_VERIFY = 2'b10;
    localparam logic [1:0] MODE_BOTH   = 2'b11;

    // Callers truncate the result to the RAM word width; only the low
    // address bits take part in the pattern.
    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/mem_sweep_cmp.sv
// rtl/mem_sweep_cmp.sv - verify pipeline register, mismatch detect, saturating error count, first-error latch
module mem_sweep_cmp
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic [31:0]        addr,
    input  logic [WID_MEM-1:0] dout,
    input  logic [WID_MEM-1:0] seed_q,
    output logic [31:0]        p,
    output logic               v,
    output logic [15:0]        err_count,
    output logic               first_err_valid,
    output logic [31:0]        first_err_addr
);

    logic [WID_MEM-1:0] exp_word;
    logic               mismatch;

    // dout arriving this cycle belongs to the address read last cycle (p).
    assign exp_word = WID_MEM'(pat(p, 32'(seed_q)));
    assign mismatch = v && (dout != exp_word);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            p               <= 32'd0;
            v               <= 1'b0;
            err_count       <= 16'd0;
            first_err_valid <= 1'b0;
            first_err_addr  <= 32'd0;
        end else begin
            p <= addr;
            v <= shift;
            if (mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= p;
                end
            end
        end
    end

endmodule

// File: rtl/mem_sweep_ctrl.sv
// rtl/mem_sweep_ctrl.sv - fill/verify sweep sequencer for the no-write-enable block RAM wrapper
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM   = 2,
    parameter int DEPTH_MEM = 32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WID_MEM-1:0] seed,
    output logic [31:0]        raddr,
    output logic [31:0]        waddr,
    output logic [WID_MEM-1:0] din,
    input  logic [WID_MEM-1:0] dout,
    output logic               busy,
    output logic               done,
    output logic [15:0]        err_count,
    output logic               first_err_valid,
    output logic [31:0]        first_err_addr
);

    // The top word is scratch: every idle cycle writes it, so it is never swept.
    localparam logic [31:0] PARK = 32'(DEPTH_MEM - 1);
    localparam logic [31:0] LAST = 32'(DEPTH_MEM - 2);

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        a_q;
    logic [WID_MEM-1:0] seed_q;
    logic               verify_after_q;
    logic               accept;
    logic [31:0]        p;
    logic               v;

    assign accept = (state_q == ST_IDLE) && start && (mode != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = mode[0] ? ST_FILL : ST_VERIFY;
                end
            end
            ST_FILL: begin
                if (a_q == LAST) begin
                    state_d = verify_after_q ? ST_VERIFY : ST_DONE;
                end
            end
            ST_VERIFY: begin
                if (a_q == LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        raddr = PARK;
        waddr = PARK;
        din   = '0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_FILL: begin
                busy  = 1'b1;
                raddr = a_q;
                waddr = a_q;
                din   = WID_MEM'(pat(a_q, 32'(seed_q)));
            end
            ST_VERIFY, ST_DRAIN: begin
                busy = 1'b1;
                if (state_q == ST_VERIFY) begin
                    raddr = a_q;
                end
                // Write back what was just read so the unconditional write
                // leaves the checked word untouched; p always trails raddr.
                if (v) begin
                    waddr = p;
                    din   = dout;
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q            <= 32'd0;
            seed_q         <= '0;
            verify_after_q <= 1'b0;
        end else if (accept) begin
            a_q            <= 32'd0;
            seed_q         <= seed;
            verify_after_q <= mode[1];
        end else if ((state_q == ST_FILL) || (state_q == ST_VERIFY)) begin
            a_q <= (a_q == LAST) ? 32'd0 : a_q + 32'd1;
        end
    end

    mem_sweep_cmp #(
        .WID_MEM(WID_MEM)
    ) u_cmp (
        .clk            (clk),
        .reset          (reset),
        .clear          (accept),
        .shift          (state_q == ST_VERIFY),
        .addr           (a_q),
        .dout           (dout),
        .seed_q         (seed_q),
        .p              (p),
        .v              (v),
        .err_count      (err_count),
        .first_err_valid(first_err_valid),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb/tb_mem_sweep_ctrl.sv - directed vector bench for mem_sweep_ctrl with behavioural RAM models
module tb_mem_sweep_ctrl;

    localparam int DS = 16;
    localparam int DB = 70000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode  = 2'b00;
    logic [1:0]  seed  = 2'b00;
    logic [31:0] raddr, waddr;
    logic [1:0]  din, dout;
    logic        busy, done, fev;
    logic [15:0] err;
    logic [31:0] fea;
    logic [1:0]  mem_s [DS];

    // saturation instance
    logic        reset_b = 1'b1;
    logic        start_b = 1'b0;
    logic [1:0]  mode_b  = 2'b00;
    logic [1:0]  seed_b  = 2'b00;
    logic [31:0] raddr_b, waddr_b;
    logic [1:0]  din_b, dout_b;
    logic        busy_b, done_b, fev_b;
    logic [15:0] err_b;
    logic [31:0] fea_b;
    logic [1:0]  mem_b [DB];

    int n_vec = 0;
    int n_err = 0;

    mem_sweep_ctrl #(.WID_MEM(2), .DEPTH_MEM(DS)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .raddr(raddr), .waddr(waddr), .din(din), .dout(dout),
        .busy(busy), .done(done), .err_count(err),
        .first_err_valid(fev), .first_err_addr(fea)
    );

    mem_sweep_ctrl #(.WID_MEM(2), .DEPTH_MEM(DB)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .mode(mode_b), .seed(seed_b),
        .raddr(raddr_b), .waddr(waddr_b), .din(din_b), .dout(dout_b),
        .busy(busy_b), .done(done_b), .err_count(err_b),
        .first_err_valid(fev_b), .first_err_addr(fea_b)
    );

    // read-first RAMs with registered output and unconditional write
    always @(posedge clk) begin
        dout <= mem_s[raddr[3:0]];
        mem_s[waddr[3:0]] <= din;
    end

    always @(posedge clk) begin
        dout_b <= mem_b[raddr_b[16:0]];
        mem_b[waddr_b[16:0]] <= din_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a run on the small instance and returns the done cycle and busy
    // cycle count; optional extra start pulses land while the run is busy.
    task automatic run(input logic [1:0] m, input logic [1:0] s, input bit pulses,
                       output int done_cyc, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; mode = m; seed = s;
        @(negedge clk);
        start = 1'b0;
        done_cyc = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 200; k++) begin
            if (busy) busy_cnt++;
            if (pulses && (k == 5 || k == 20 || k == 31 || k == 32)) begin
                start = 1'b1; mode = 2'b01;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        if (start) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  seed;
        int          inj_addr;
        logic [1:0]  inj_val;
        int          exp_done;
        logic [15:0] exp_err;
        logic        exp_fev;
        logic [31:0] exp_fea;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int dc, bc;
        bit ok;
        for (int i = 0; i < DS; i++) mem_s[i] = 2'b00;
        for (int i = 0; i < DB; i++) mem_b[i] = 2'(i);

        vecs[0] = '{2'b11, 2'b01, -1, 2'b00, 32, 16'd0,  1'b0, 32'd0};
        vecs[1] = '{2'b01, 2'b00, -1, 2'b00, 16, 16'd0,  1'b0, 32'd0};
        vecs[2] = '{2'b10, 2'b00,  9, 2'b10, 17, 16'd1,  1'b1, 32'd9};
        vecs[3] = '{2'b01, 2'b00, -1, 2'b00, 16, 16'd0,  1'b0, 32'd0};
        vecs[4] = '{2'b10, 2'b11, -1, 2'b00, 17, 16'd15, 1'b1, 32'd0};
        vecs[5] = '{2'b10, 2'b00, -1, 2'b00, 17, 16'd0,  1'b0, 32'd0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        reset_b = 1'b0;

        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err),  32'd0);
        check("rst_fev",   32'(fev),  32'd0);
        check("rst_fea",   fea,       32'd0);
        check("rst_raddr", raddr,     32'd15);
        check("rst_waddr", waddr,     32'd15);
        check("rst_din",   32'(din),  32'd0);

        fork
            begin : small_tests
                for (int i = 0; i < 6; i++) begin
                    if (vecs[i].inj_addr >= 0) mem_s[vecs[i].inj_addr] = vecs[i].inj_val;
                    run(vecs[i].mode, vecs[i].seed, 1'b0, dc, bc);
                    check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(vecs[i].exp_done));
                    check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].exp_done - 1));
                    check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
                    check($sformatf("v%0d_fev", i), 32'(fev), 32'(vecs[i].exp_fev));
                    check($sformatf("v%0d_fea", i), fea, vecs[i].exp_fea);
                    if (i == 0) begin
                        check("v0_ram5", 32'(mem_s[5]), 32'd0);
                        check("v0_ram6", 32'(mem_s[6]), 32'd3);
                    end
                    if (i == 2) check("v2_ram9_kept", 32'(mem_s[9]), 32'd2);
                    if (i == 4) begin
                        ok = 1'b1;
                        for (int a = 0; a < DS - 1; a++) if (mem_s[a] !== 2'(a)) ok = 1'b0;
                        check("v4_ram_unchanged", 32'(ok), 32'd1);
                    end
                end

                // results hold across a mode-00 start
                run(2'b10, 2'b11, 1'b0, dc, bc);
                @(negedge clk);
                start = 1'b1; mode = 2'b00;
                @(negedge clk);
                start = 1'b0;
                bc = 0;
                for (int k = 0; k < 6; k++) begin
                    if (busy || done) bc++;
                    @(negedge clk);
                end
                check("mode00_no_activity", 32'(bc), 32'd0);
                check("mode00_err_held", 32'(err), 32'd15);
                check("mode00_fev_held", 32'(fev), 32'd1);

                // start pulses while busy are dropped
                run(2'b11, 2'b01, 1'b1, dc, bc);
                check("ign_done_cycle", 32'(dc), 32'd32);
                check("ign_busy_cycles", 32'(bc), 32'd31);
                check("ign_err", 32'(err), 32'd0);
                repeat (3) @(negedge clk);
                check("ign_no_restart", 32'(busy), 32'd0);
                ok = 1'b1;
                for (int a = 0; a < DS - 1; a++) if (mem_s[a] !== (2'(a) ^ 2'b01)) ok = 1'b0;
                check("ign_ram_pattern", 32'(ok), 32'd1);

                // reset in verify cycle 7: every word mismatches with seed 2
                @(negedge clk);
                start = 1'b1; mode = 2'b10; seed = 2'b10;
                @(negedge clk);
                start = 1'b0;
                repeat (6) @(negedge clk);
                check("mid_err_before_reset", 32'(err), 32'd5);
                check("mid_fev_before_reset", 32'(fev), 32'd1);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("mid_rst_busy",  32'(busy), 32'd0);
                check("mid_rst_err",   32'(err),  32'd0);
                check("mid_rst_fev",   32'(fev),  32'd0);
                check("mid_rst_raddr", raddr,     32'd15);
                check("mid_rst_waddr", waddr,     32'd15);
                check("mid_rst_din",   32'(din),  32'd0);
                run(2'b11, 2'b10, 1'b0, dc, bc);
                check("fresh_done_cycle", 32'(dc), 32'd32);
                check("fresh_err", 32'(err), 32'd0);
                check("fresh_fev", 32'(fev), 32'd0);
            end
            begin : sat_test
                int dcb;
                @(negedge clk);
                start_b = 1'b1; mode_b = 2'b10; seed_b = 2'b11;
                @(negedge clk);
                start_b = 1'b0;
                dcb = -1;
                for (int k = 1; k <= 71000; k++) begin
                    if (done_b) begin
                        dcb = k;
                        break;
                    end
                    @(negedge clk);
                end
                check("sat_done_cycle", 32'(dcb), 32'd70001);
                check("sat_err", 32'(err_b), 32'h0000FFFF);
                check("sat_fev", 32'(fev_b), 32'd1);
                check("sat_fea", fea_b, 32'd0);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
